alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 94 +++++++++
 tb/tb_alu_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared combinational ALU, with a one-entry tagged response buffer.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [DATA_WIDTH-1:0] r0_a,
    input  logic [DATA_WIDTH-1:0] r0_b,
    input  logic [OP_WIDTH-1:0]   r0_op,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [DATA_WIDTH-1:0] r1_a,
    input  logic [DATA_WIDTH-1:0] r1_b,
    input  logic [OP_WIDTH-1:0]   r1_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_ready
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state;
    logic       last_grant;
    logic       can_accept;
    logic       winner;
    logic       grant;

    // Readies are held low while reset is high, so no grant can race the buffer clear.
    assign can_accept = !reset && ((state == EMPTY) || rsp_ready);

`ifdef ALU_ARB_RR_EN
    always_comb begin
        winner = 1'b0;
        if (r0_valid && r1_valid) winner = ~last_grant;
        else if (r1_valid)        winner = 1'b1;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = 1'b0;
        if (!r0_valid && r1_valid) winner = 1'b1;
    end
`endif

    assign grant    = can_accept && (r0_valid || r1_valid);
    assign r0_ready = grant && !winner;
    assign r1_ready = grant && winner;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (r0_ready) begin
            alu_a  = r0_a;
            alu_b  = r0_b;
            alu_op = r0_op;
        end else if (r1_ready) begin
            alu_a  = r1_a;
            alu_b  = r1_b;
            alu_op = r1_op;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= EMPTY;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            last_grant <= 1'b1;
        end else if (grant) begin
            state      <= FULL;
            rsp_id     <= winner;
            rsp_data   <= alu_out;
            last_grant <= winner;
        end else if ((state == FULL) && rsp_ready) begin
            state <= EMPTY;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected responses, a monitor pops and compares.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          r0_valid, r1_valid;
    logic          r0_ready, r1_ready;
    logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [OW-1:0] r0_op, r1_op;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [OW-1:0] alu_op;
    logic          rsp_valid, rsp_id, rsp_ready;
    logic [DW-1:0] rsp_data;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW:0] sb[$];

    always #5 clock = ~clock;

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    // Stand-in for the external combinational ALU.
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a << alu_b[4:0];
            4'b0011: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = alu_a >> alu_b[4:0];
            4'b0111: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1000: alu_out = alu_a | alu_b;
            4'b1001: alu_out = alu_a & alu_b;
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: each negedge with a valid response and rsp_ready high is a handshake at the next edge.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h expected no response", rsp_id, rsp_data);
            end else begin
                logic [DW:0] e;
                e = sb.pop_front();
                check("rsp_id", {31'd0, rsp_id}, {31'd0, e[DW]});
                check("rsp_data", rsp_data, e[DW-1:0]);
            end
        end
    end

    // One cycle: inputs already driven; check grants and ALU drive at negedge, log expected response.
    task automatic cyc(input logic er0, input logic er1, input logic [DW-1:0] edata);
        @(negedge clock);
        check("r0_ready", {31'd0, r0_ready}, {31'd0, er0});
        check("r1_ready", {31'd0, r1_ready}, {31'd0, er1});
        if (er0) begin
            check("alu_a", alu_a, r0_a);
            check("alu_b", alu_b, r0_b);
            check("alu_op", {28'd0, alu_op}, {28'd0, r0_op});
        end else if (er1) begin
            check("alu_a", alu_a, r1_a);
            check("alu_b", alu_b, r1_b);
            check("alu_op", {28'd0, alu_op}, {28'd0, r1_op});
        end else begin
            check("alu_idle", {alu_a ^ alu_b, 28'd0, alu_op} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        end
        if (er0 || er1) sb.push_back({er1, edata});
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        r0_a = '0; r0_b = '0; r0_op = '0;
        r1_a = '0; r1_b = '0; r1_op = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Single request: r0 add 5+7
        r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = 4'b0000;
        cyc(1'b1, 1'b0, 32'd12);
        r0_valid = 1'b0;
        check("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        cyc(1'b0, 1'b0, 32'd0);

        // Illegal opcode from r1
        r1_valid = 1'b1; r1_a = 32'd3; r1_b = 32'd4; r1_op = 4'b1111;
        cyc(1'b0, 1'b1, 32'd0);
        r1_valid = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);

        // Contention: r0 sub 10-3, r1 xor 0xF0^0x0F
        r0_valid = 1'b1; r0_a = 32'd10; r0_b = 32'd3; r0_op = 4'b0001;
        r1_valid = 1'b1; r1_a = 32'hF0; r1_b = 32'h0F; r1_op = 4'b0100;
`ifdef ALU_ARB_RR_EN
        cyc(1'b1, 1'b0, 32'd7);
        cyc(1'b0, 1'b1, 32'hFF);
        cyc(1'b1, 1'b0, 32'd7);
        cyc(1'b0, 1'b1, 32'hFF);
`else
        repeat (4) cyc(1'b1, 1'b0, 32'd7);
`endif
        r0_valid = 1'b0; r1_valid = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);

        // Backpressure: r1 sll 1<<4 fills buffer, then r0 waits while rsp_ready is low
        r1_valid = 1'b1; r1_a = 32'd1; r1_b = 32'd4; r1_op = 4'b0010;
        cyc(1'b0, 1'b1, 32'd16);
        r1_valid = 1'b0;
        r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = 4'b0000;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'd0);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, 32'd16);
        end
        rsp_ready = 1'b1;
        cyc(1'b1, 1'b0, 32'd12);
        check("refill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        r0_valid = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);

        // Reset mid-flight: 12 buffered and held, then discarded by reset
        rsp_ready = 1'b0;
        r0_valid = 1'b1;
        cyc(1'b1, 1'b0, 32'd12);
        r0_valid = 1'b0;
        check("pre_reset_rsp_data", rsp_data, 32'd12);
        void'(sb.pop_back());
        reset = 1'b1;
        r0_valid = 1'b1; r0_a = 32'd10; r0_b = 32'd3; r0_op = 4'b0001;
        r1_valid = 1'b1;
        r1_a = 32'hF0; r1_b = 32'h0F; r1_op = 4'b0100;
        cyc(1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        check("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_reset_rsp_data", rsp_data, 32'd0);
        rsp_ready = 1'b1;
        cyc(1'b1, 1'b0, 32'd7);
        r0_valid = 1'b0; r1_valid = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
